voice_mixer: RTL and testbench
==============================

Name: voice_mixer

Overview:
- Parametrised successor to the fixed 8-voice wrap-around summer in the synth top.
- Mixes N_VOICES signed oscillator samples with per-voice gain, per-voice mute and master gain.
- Uses a time-multiplexed multiply-accumulate, so only one multiplier is needed.
- Saturates the result to the output width and hands the mixed sample to the filter/audio path over a valid/ready handshake.
- Runs on CLOCK_50. Starts one mix per sample_tick; sample_tick is a single-cycle strobe already synchronised from the DAC LR clock.

Parameters:
- N_VOICES, 8, number of voice inputs (at least 2).
- SAMPLE_W, 16, signed sample width, both inputs and output.
- GAIN_W, 8, unsigned gain width. Format Q1.(GAIN_W-1), so 0x80 is unity for GAIN_W=8.

Ports:
- Clk  in  1  system clock (CLOCK_50).
- Reset_n  in  1  asynchronous, active-low reset.
- sample_tick  in  1  one-cycle strobe that starts a mix.
- voice_in  in  N_VOICES*SAMPLE_W  packed signed samples; voice k at [k*SAMPLE_W +: SAMPLE_W].
- voice_gain  in  N_VOICES*GAIN_W  packed unsigned per-voice gains.
- voice_mute  in  N_VOICES  1 = voice contributes 0.
- master_gain  in  GAIN_W  unsigned master gain.
- out_sample  out  SAMPLE_W  mixed, saturated sample.
- out_valid  out  1  out_sample is valid.
- out_ready  in  1  consumer accepts the sample.
- busy  out  1  high in any state other than IDLE.
- clip_sticky  out  1  saturation has occurred since the last clear.
- overrun_sticky  out  1  a sample_tick was dropped.
- clr_flags  in  1  one-cycle pulse that clears the sticky flags.
- peak_abs  out  SAMPLE_W  peak magnitude (see Optional Feature).

Behaviour:
- Reset (async, Reset_n=0):
  - state=IDLE, accumulator=0, voice index=0.
  - out_sample=0, out_valid=0, busy=0, clip_sticky=0, overrun_sticky=0, peak_abs=0.
- State IDLE: on sample_tick=1, snapshot voice_in, voice_gain, voice_mute and master_gain into registers, clear the accumulator, set index=0, go to ACCUM.
- State ACCUM: one voice per cycle.
  - acc += mute[k] ? 0 : signed(sample[k]) * unsigned(gain[k]).
  - After k = N_VOICES-1, go to SCALE.
  - Width: ACC_W = SAMPLE_W + GAIN_W + 1 + clog2(N_VOICES). No overflow is possible.
- State SCALE (single cycle):
  - t = (acc * master_gain) >>> (2*(GAIN_W-1)); the shift is arithmetic and truncates toward -infinity.
  - Saturate t to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1] and register it into out_sample.
  - If clamped, set clip_sticky.
  - Set out_valid=1 and go to OUTPUT.
- State OUTPUT:
  - Hold out_sample and out_valid stable while out_ready=0.
  - On out_valid && out_ready, clear out_valid and go to IDLE.
  - If sample_tick is also high in that same cycle, accept it as if in IDLE: snapshot and go straight to ACCUM.
- Latency: out_valid rises on the (N_VOICES+1)th rising edge after the edge that samples sample_tick. That is 9 cycles for N_VOICES=8.
- sample_tick in ACCUM or SCALE, or in OUTPUT without a completing handshake: the tick is ignored and overrun_sticky is set. The in-flight mix and held output are unaffected.
- Inputs may change freely after the snapshot; only snapshot values are used.
- clr_flags clears both sticky flags (and peak_abs when the optional feature is compiled in). If a set and a clear occur in the same cycle, set wins.
- Reset asserted mid-mix aborts the mix; nothing is output for it.

Optional Feature:
- Macro: VOICE_MIXER_PEAK_EN.
- Defined:
  - On each completed output transfer, peak_abs = max(peak_abs, |out_sample|).
  - |-2^(SAMPLE_W-1)| saturates to 2^(SAMPLE_W-1)-1.
  - clr_flags resets peak_abs to 0; a same-cycle update wins.
- Undefined: peak_abs is tied to 0 and no peak logic is synthesised.

Test Plan (N_VOICES=8, SAMPLE_W=16, GAIN_W=8):
- All voices 0x0100, gains 0x80, master 0x80, no mute, tick -> out_valid 9 cycles later, out_sample=0x0800, clip_sticky=0.
- All voices 0x7FFF at unity gain -> 0x7FFF and clip_sticky=1. All voices 0x8000 -> 0x8000. clr_flags -> clip_sticky=0.
- voice0=0x1234 with gain 0x40, voices 1-7 muted with non-zero data, master 0x80 -> 0x091A.
- voice0=0xFFFF with gain 0x01, others muted, master 0x80 -> 0xFFFF (truncation toward -infinity).
- out_ready held low 20 cycles, second tick 12 cycles after the first -> out_sample stable throughout, overrun_sticky=1, exactly one transfer once ready rises. Separately, handshake and tick in the same cycle -> next mix starts with no overrun.
- Reset_n pulsed low during ACCUM -> out_valid=0 and busy=0 immediately. The next tick with the first test's stimulus -> 0x0800.

Source files
------------

// File: rtl/voice_mixer.sv
// Parametrised voice mixer: per-voice gain and mute, one shared multiplier, master gain, saturation, valid/ready output.
// Optional peak-magnitude tracker is compiled in with `define VOICE_MIXER_PEAK_EN.
module voice_mixer #(
    parameter int N_VOICES = 8,
    parameter int SAMPLE_W = 16,
    parameter int GAIN_W   = 8
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         sample_tick,
    input  logic [N_VOICES*SAMPLE_W-1:0] voice_in,
    input  logic [N_VOICES*GAIN_W-1:0]   voice_gain,
    input  logic [N_VOICES-1:0]          voice_mute,
    input  logic [GAIN_W-1:0]            master_gain,
    output logic [SAMPLE_W-1:0]          out_sample,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         clip_sticky,
    output logic                         overrun_sticky,
    input  logic                         clr_flags,
    output logic [SAMPLE_W-1:0]          peak_abs
);

    localparam int IDX_W    = $clog2(N_VOICES);
    localparam int PROD_W   = SAMPLE_W + GAIN_W + 1;
    localparam int ACC_W    = SAMPLE_W + GAIN_W + 1 + IDX_W;
    localparam int SCALED_W = ACC_W + GAIN_W + 1;
    localparam int SHIFT    = 2 * (GAIN_W - 1);

    localparam logic [IDX_W-1:0]           LAST_IDX = IDX_W'(N_VOICES - 1);
    localparam logic signed [SCALED_W-1:0] SAT_MAX  = {{(SCALED_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SCALED_W-1:0] SAT_MIN  = {{(SCALED_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};
    localparam logic [SAMPLE_W-1:0]        OUT_MAX  = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [SAMPLE_W-1:0]        OUT_MIN  = {1'b1, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, SCALE, OUTPUT} state_t;

    state_t                         state;
    logic [IDX_W-1:0]               idx;
    logic signed [ACC_W-1:0]        acc;
    logic [N_VOICES*SAMPLE_W-1:0]   snap_voice;
    logic [N_VOICES*GAIN_W-1:0]     snap_gain;
    logic [N_VOICES-1:0]            snap_mute;
    logic [GAIN_W-1:0]              snap_master;

    logic signed [SAMPLE_W-1:0]     cur_sample;
    logic signed [GAIN_W:0]         cur_gain;
    logic signed [GAIN_W:0]         master_s;
    logic signed [PROD_W-1:0]       product;
    logic signed [ACC_W-1:0]        term;
    logic signed [SCALED_W-1:0]     scaled;
    logic signed [SCALED_W-1:0]     t;
    logic [SAMPLE_W-1:0]            sat_val;
    logic                           clip_now;
    logic                           start;
    logic                           transfer;
    logic                           clip_set;
    logic                           overrun_set;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cur_sample = snap_voice[idx*SAMPLE_W +: SAMPLE_W];
        cur_gain   = {1'b0, snap_gain[idx*GAIN_W +: GAIN_W]};
        master_s   = {1'b0, snap_master};
        product    = PROD_W'(cur_sample) * PROD_W'(cur_gain);
        term       = snap_mute[idx] ? '0 : ACC_W'(product);
        scaled     = SCALED_W'(acc) * SCALED_W'(master_s);
        t          = scaled >>> SHIFT;
        sat_val    = t[SAMPLE_W-1:0];
        clip_now   = 1'b0;
        if (t > SAT_MAX) begin
            sat_val  = OUT_MAX;
            clip_now = 1'b1;
        end else if (t < SAT_MIN) begin
            sat_val  = OUT_MIN;
            clip_now = 1'b1;
        end
    end

    // A tick is taken in IDLE or on the cycle the held output is accepted; anywhere else it is dropped.
    assign transfer    = (state == OUTPUT) && out_ready;
    assign start       = sample_tick && ((state == IDLE) || transfer);
    assign clip_set    = (state == SCALE) && clip_now;
    assign overrun_set = sample_tick && !start;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state          <= IDLE;
            idx            <= '0;
            acc            <= '0;
            out_sample     <= '0;
            out_valid      <= 1'b0;
            busy           <= 1'b0;
            clip_sticky    <= 1'b0;
            overrun_sticky <= 1'b0;
            // NOTE: snapshot registers are reset too so the datapath never carries X into acc.
            snap_voice     <= '0;
            snap_gain      <= '0;
            snap_mute      <= '0;
            snap_master    <= '0;
        end else begin
            // NOTE: set is OR-ed after the clear term so a same-cycle set wins over clr_flags.
            clip_sticky    <= clip_set    | (clip_sticky    & ~clr_flags);
            overrun_sticky <= overrun_set | (overrun_sticky & ~clr_flags);

            if (start) begin
                snap_voice  <= voice_in;
                snap_gain   <= voice_gain;
                snap_mute   <= voice_mute;
                snap_master <= master_gain;
                acc         <= '0;
                idx         <= '0;
                out_valid   <= 1'b0;
                busy        <= 1'b1;
                state       <= ACCUM;
            end else begin
                case (state)
                    ACCUM: begin
                        acc <= acc + term;
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= SCALE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    SCALE: begin
                        out_sample <= sat_val;
                        out_valid  <= 1'b1;
                        state      <= OUTPUT;
                    end
                    OUTPUT: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef VOICE_MIXER_PEAK_EN
    logic [SAMPLE_W-1:0] out_abs;

    always_comb begin
        out_abs = out_sample;
        if (out_sample == OUT_MIN) begin
            out_abs = OUT_MAX;
        end else if (out_sample[SAMPLE_W-1]) begin
            out_abs = -out_sample;
        end
    end

    // A transfer in the same cycle as a clear restarts tracking from that sample.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            peak_abs <= '0;
        end else if (transfer) begin
            if (clr_flags || (out_abs > peak_abs)) begin
                peak_abs <= out_abs;
            end
        end else if (clr_flags) begin
            peak_abs <= '0;
        end
    end
`else
    assign peak_abs = '0;
`endif

endmodule

// File: tb/tb_voice_mixer.sv
// Directed self-checking bench for voice_mixer (N_VOICES=8, SAMPLE_W=16, GAIN_W=8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_voice_mixer;

    localparam int NV = 8;
    localparam int SW = 16;
    localparam int GW = 8;

    logic              Clk;
    logic              Reset_n;
    logic              sample_tick;
    logic [NV*SW-1:0]  voice_in;
    logic [NV*GW-1:0]  voice_gain;
    logic [NV-1:0]     voice_mute;
    logic [GW-1:0]     master_gain;
    logic [SW-1:0]     out_sample;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              clip_sticky;
    logic              overrun_sticky;
    logic              clr_flags;
    logic [SW-1:0]     peak_abs;

    int n_checks = 0;
    int n_pass   = 0;

    voice_mixer #(.N_VOICES(NV), .SAMPLE_W(SW), .GAIN_W(GW)) dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .sample_tick    (sample_tick),
        .voice_in       (voice_in),
        .voice_gain     (voice_gain),
        .voice_mute     (voice_mute),
        .master_gain    (master_gain),
        .out_sample     (out_sample),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .busy           (busy),
        .clip_sticky    (clip_sticky),
        .overrun_sticky (overrun_sticky),
        .clr_flags      (clr_flags),
        .peak_abs       (peak_abs)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic set_all(input logic [SW-1:0] s, input logic [GW-1:0] g);
        for (int k = 0; k < NV; k++) begin
            voice_in[k*SW +: SW]   = s;
            voice_gain[k*GW +: GW] = g;
        end
        voice_mute  = '0;
        master_gain = 8'h80;
    endtask

    // Voice 0 alone with the given sample and gain; the others carry junk but are muted.
    task automatic set_solo(input logic [SW-1:0] s, input logic [GW-1:0] g);
        set_all(16'h5555, 8'h80);
        voice_in[0 +: SW]   = s;
        voice_gain[0 +: GW] = g;
        voice_mute          = 8'hFE;
    endtask

    // Leaves the bench on the falling edge just after the edge that samples the tick.
    task automatic start_mix();
        @(negedge Clk) sample_tick = 1'b1;
        @(negedge Clk) sample_tick = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge Clk);
            lat++;
        end
    endtask

    task automatic pulse_clr();
        @(negedge Clk) clr_flags = 1'b1;
        @(negedge Clk) clr_flags = 1'b0;
    endtask

    initial begin
        int lat;
        int transfers;
        bit stable;

        Reset_n     = 1'b0;
        sample_tick = 1'b0;
        out_ready   = 1'b1;
        clr_flags   = 1'b0;
        set_all(16'h0000, 8'h00);
        master_gain = 8'h00;

        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        check("rst_out_sample", 32'(out_sample), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_clip", 32'(clip_sticky), 32'h0);
        check("rst_overrun", 32'(overrun_sticky), 32'h0);
        check("rst_peak", 32'(peak_abs), 32'h0);

        // Eight voices of 0x0100 at unity everywhere: 8*0x0100 = 0x0800.
        set_all(16'h0100, 8'h80);
        start_mix();
        check("basic_busy", 32'(busy), 32'h1);
        set_all(16'h7FFF, 8'h80);
        wait_valid(lat);
        check("basic_latency", 32'(lat), 32'd9);
        check("basic_sample", 32'(out_sample), 32'h0800);
        check("basic_clip", 32'(clip_sticky), 32'h0);
        @(negedge Clk);
        check("basic_valid_drop", 32'(out_valid), 32'h0);
        check("basic_idle", 32'(busy), 32'h0);

        set_all(16'h7FFF, 8'h80);
        start_mix();
        wait_valid(lat);
        check("pos_sat_sample", 32'(out_sample), 32'h7FFF);
        check("pos_sat_clip", 32'(clip_sticky), 32'h1);

        set_all(16'h8000, 8'h80);
        start_mix();
        wait_valid(lat);
        check("neg_sat_sample", 32'(out_sample), 32'h8000);

        pulse_clr();
        check("clr_clip", 32'(clip_sticky), 32'h0);

        // 0x1234 * 0x40/0x80 = 0x091A.
        set_solo(16'h1234, 8'h40);
        start_mix();
        wait_valid(lat);
        check("mute_half_sample", 32'(out_sample), 32'h091A);

        // -1 * 1/128 floors to -1.
        set_solo(16'hFFFF, 8'h01);
        start_mix();
        wait_valid(lat);
        check("floor_sample", 32'(out_sample), 32'hFFFF);
        check("floor_clip", 32'(clip_sticky), 32'h0);
        @(negedge Clk);

        // Back-pressure: ready low for 20 cycles, second tick lands while the output is held.
        out_ready = 1'b0;
        set_all(16'h0100, 8'h80);
        start_mix();
        stable = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge Clk);
            if (i == 2) set_all(16'h7FFF, 8'h80);
            if (i == 11) sample_tick = 1'b1;
            if (i == 12) sample_tick = 1'b0;
            if (i >= 9 && !(out_valid === 1'b1 && out_sample === 16'h0800)) stable = 1'b0;
        end
        check("hold_stable", 32'(stable), 32'h1);
        check("hold_overrun", 32'(overrun_sticky), 32'h1);
        check("hold_sample", 32'(out_sample), 32'h0800);
        out_ready = 1'b1;
        transfers = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid && out_ready) transfers++;
            @(negedge Clk);
        end
        check("hold_one_transfer", 32'(transfers), 32'd1);
        check("hold_idle", 32'(busy), 32'h0);

        pulse_clr();
        check("clr_overrun", 32'(overrun_sticky), 32'h0);

        // Handshake and new tick in the same cycle.
        out_ready = 1'b0;
        set_all(16'h0100, 8'h80);
        start_mix();
        wait_valid(lat);
        check("b2b_first_sample", 32'(out_sample), 32'h0800);
        set_solo(16'hFFFF, 8'h01);
        out_ready   = 1'b1;
        sample_tick = 1'b1;
        @(negedge Clk) sample_tick = 1'b0;
        check("b2b_valid_drop", 32'(out_valid), 32'h0);
        check("b2b_busy", 32'(busy), 32'h1);
        wait_valid(lat);
        check("b2b_latency", 32'(lat), 32'd9);
        check("b2b_sample", 32'(out_sample), 32'hFFFF);
        check("b2b_no_overrun", 32'(overrun_sticky), 32'h0);
        @(negedge Clk);

        // Reset in the middle of accumulation aborts the mix.
        set_all(16'h7FFF, 8'h80);
        start_mix();
        repeat (3) @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        check("abort_valid", 32'(out_valid), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        @(negedge Clk) Reset_n = 1'b1;
        repeat (12) @(negedge Clk);
        check("abort_no_output", 32'(out_valid), 32'h0);
        set_all(16'h0100, 8'h80);
        start_mix();
        wait_valid(lat);
        check("after_abort_latency", 32'(lat), 32'd9);
        check("after_abort_sample", 32'(out_sample), 32'h0800);
        @(negedge Clk);

`ifndef VOICE_MIXER_PEAK_EN
        check("peak_tied_zero", 32'(peak_abs), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
